// File: rtl/tick_timer.sv
// Programmable one-shot / periodic down-counter driven by an external tick pulse.
// Optional overrun flag built only when TICK_TIMER_OVERRUN_EN is defined.
module tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_periodic,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr_sticky,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_count,
    output logic             o_expire,
    output logic             o_expire_sticky,
    output logic             o_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             periodic_q;
    logic             expire_q;
    logic             sticky_q;
    logic             expiry_d;

    // Expiry only on an accepted tick: stop, start and pause all take precedence.
    // A count of 0 (load value 0) expires like a count of 1.
    assign expiry_d = (state_q == S_RUN) && !i_stop && !i_start && !i_pause &&
                      i_tick && (count_q <= WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            expire_q <= expiry_d;
            if (expiry_d)
                sticky_q <= 1'b1;
            else if (i_clr_sticky)
                sticky_q <= 1'b0;

            if (i_stop) begin
                state_q <= S_IDLE;
                count_q <= '0;
            end else if (i_start) begin
                state_q    <= S_RUN;
                reload_q   <= i_load_val;
                periodic_q <= i_periodic;
                count_q    <= i_load_val;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (i_pause) begin
                            state_q <= S_PAUSED;
                        end else if (i_tick) begin
                            if (count_q <= WIDTH'(1)) begin
                                if (periodic_q) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q <= '0;
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                count_q <= count_q - WIDTH'(1);
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (!i_pause)
                            state_q <= S_RUN;
                    end
                    S_IDLE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TICK_TIMER_OVERRUN_EN
    logic overrun_q;

    // An expiry landing while the sticky flag is still unserviced is an overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            overrun_q <= 1'b0;
        else if (expiry_d && sticky_q)
            overrun_q <= 1'b1;
        else if (i_clr_sticky)
            overrun_q <= 1'b0;
    end

    assign o_overrun = overrun_q;
`else
    assign o_overrun = 1'b0;
`endif

    assign o_busy          = (state_q != S_IDLE);
    assign o_count         = count_q;
    assign o_expire        = expire_q;
    assign o_expire_sticky = sticky_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer; expiry pulses are checked against a queue of
// expected post-expiry counts filled as the expiring ticks are driven.
module tb_tick_timer;
    localparam int W = 16;

`ifdef TICK_TIMER_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic         periodic = 1'b0, clr = 1'b0;
    logic [W-1:0] load = '0;
    logic         busy, expire, sticky, overrun;
    logic [W-1:0] count;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    tick_timer #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start),
        .i_stop(stop), .i_pause(pause), .i_periodic(periodic),
        .i_load_val(load), .i_clr_sticky(clr),
        .o_busy(busy), .o_count(count), .o_expire(expire),
        .o_expire_sticky(sticky), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each expiry pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && expire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_expire", 32'(expire), 32'd0);
            end else begin
                chk("expire_count", 32'(count), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_start(input logic [W-1:0] v, input logic per);
        load = v; periodic = per; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_tick(input logic expiring, input logic [W-1:0] after);
        tick = 1'b1;
        if (expiring) exp_q.push_back(after);
        step();
        tick = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_expire", 32'(expire), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step();

        // one-shot, interval 3, tick every 4 clocks
        do_start(16'd3, 1'b0);
        chk("os_busy", 32'(busy), 1);
        chk("os_load", 32'(count), 3);
        for (int k = 1; k <= 3; k++) begin
            step(); step(); step();
            do_tick(k == 3, 16'd0);
            chk("os_count", 32'(count), 32'(3 - k));
        end
        chk("os_busy_end", 32'(busy), 0);
        chk("os_expire_hi", 32'(expire), 1);
        step();
        chk("os_expire_lo", 32'(expire), 0);
        chk("os_sticky", 32'(sticky), 1);
        drained("os_drained");
        do_clr();
        chk("os_clr_sticky", 32'(sticky), 0);

        // periodic, interval 2, six ticks
        do_start(16'd2, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            do_tick(k % 2 == 0, 16'd2);
            chk("per_count", 32'(count), (k % 2 == 0) ? 32'd2 : 32'd1);
            step();
        end
        chk("per_busy", 32'(busy), 1);
        chk("per_sticky", 32'(sticky), 1);
        chk("per_overrun", 32'(overrun), 32'(OVR));
        drained("per_drained");
        stop = 1'b1; step(); stop = 1'b0;
        chk("per_stop_busy", 32'(busy), 0);
        chk("per_stop_count", 32'(count), 0);
        do_clr();
        chk("per_clr_sticky", 32'(sticky), 0);
        chk("per_clr_overrun", 32'(overrun), 0);

        // pause holds count, stop aborts without expiry
        do_start(16'd5, 1'b0);
        do_tick(1'b0, '0);
        chk("pz_count1", 32'(count), 4);
        pause = 1'b1;
        do_tick(1'b0, '0);
        chk("pz_hold1", 32'(count), 4);
        do_tick(1'b0, '0);
        chk("pz_hold2", 32'(count), 4);
        chk("pz_busy", 32'(busy), 1);
        pause = 1'b0;
        step();
        do_tick(1'b0, '0);
        chk("pz_resume", 32'(count), 3);
        stop = 1'b1; step(); stop = 1'b0;
        chk("pz_stop_busy", 32'(busy), 0);
        chk("pz_stop_count", 32'(count), 0);
        step();
        chk("pz_no_expire", 32'(expire), 0);
        drained("pz_drained");

        // load 0 expires on first tick
        do_start(16'd0, 1'b0);
        do_tick(1'b1, 16'd0);
        chk("z_busy", 32'(busy), 0);
        step();
        // tick coincident with start is ignored
        tick = 1'b1;
        do_start(16'd3, 1'b0);
        tick = 1'b0;
        chk("st_tick_ign", 32'(count), 3);
        do_tick(1'b0, '0);
        chk("st_dec", 32'(count), 2);
        // restart while running
        do_start(16'd4, 1'b0);
        chk("rs_reload", 32'(count), 4);
        do_tick(1'b0, '0);
        chk("rs_dec", 32'(count), 3);
        // periodic with reload 0 expires every tick
        do_start(16'd0, 1'b1);
        do_tick(1'b1, 16'd0);
        step();
        do_tick(1'b1, 16'd0);
        chk("pz0_busy", 32'(busy), 1);
        step();
        stop = 1'b1; step(); stop = 1'b0;
        drained("edge_drained");

        // sticky: set wins over clear, overrun on unserviced expiry
        do_clr();
        chk("sk_clr", 32'(sticky), 0);
        chk("sk_ovr_clr", 32'(overrun), 0);
        do_start(16'd1, 1'b0);
        clr = 1'b1;
        do_tick(1'b1, 16'd0);
        clr = 1'b0;
        chk("sk_set_wins", 32'(sticky), 1);
        chk("sk_no_ovr", 32'(overrun), 0);
        step();
        do_start(16'd1, 1'b0);
        do_tick(1'b1, 16'd0);
        chk("sk_ovr", 32'(overrun), 32'(OVR));
        step();
        do_start(16'd1, 1'b0);
        clr = 1'b1;
        do_tick(1'b1, 16'd0);
        clr = 1'b0;
        chk("sk_ovr_set_wins", 32'(overrun), 32'(OVR));
        chk("sk_sticky2", 32'(sticky), 1);
        step();
        drained("sk_drained");
        do_clr();

        // asynchronous reset mid-run
        do_start(16'd6, 1'b1);
        do_tick(1'b0, '0);
        do_tick(1'b0, '0);
        chk("ar_count", 32'(count), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_count0", 32'(count), 0);
        chk("ar_sticky", 32'(sticky), 0);
        step(); step();
        rst_n = 1'b1;
        tick = 1'b1;
        step(); step();
        tick = 1'b0;
        step(); step();
        chk("ar_post_busy", 32'(busy), 0);
        chk("ar_post_expire", 32'(expire), 0);
        drained("ar_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
